opsum_collector: RTL

//  Downstream drain stage of the PE array output-psum global network (GON).

---
 rtl/pe_array_pkg.sv | 18 +
 rtl/opsum_wr_fifo.sv | 63 ++++++
 rtl/opsum_collector.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pe_array_pkg.sv
// Shared PE-array definitions: default GON/GLB widths and the opsum collector state set.
package pe_array_pkg;

   localparam int unsigned PSUM_DATA_SIZE = 32;
   localparam int unsigned OPSUM_NUM      = 4;
   localparam int unsigned ROW_LEN        = 4;
   localparam int unsigned ID_LEN         = 5;
   localparam int unsigned BEAT_LEN       = 8;
   localparam int unsigned ADDR_WIDTH     = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_DRAIN,
      ST_DONE
   } collector_state_e;

endpackage

// File: rtl/opsum_wr_fifo.sv
// Two-entry {addr,data} FIFO with registered head; the head feeds the GLB write port directly.
module opsum_wr_fifo #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [ADDR_WIDTH-1:0] push_addr,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [ADDR_WIDTH-1:0] head_addr,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [1:0]            count,
   output logic                  full,
   output logic                  empty
);

   logic [ADDR_WIDTH-1:0] tail_addr;
   logic [DATA_WIDTH-1:0] tail_data;
   logic                  push_ok;
   logic                  pop_ok;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= 2'd0;
         head_addr <= '0;
         head_data <= '0;
         tail_addr <= '0;
         tail_data <= '0;
      end else begin
         unique case ({push_ok, pop_ok})
            2'b10: begin
               if (empty) begin
                  head_addr <= push_addr;
                  head_data <= push_data;
               end else begin
                  tail_addr <= push_addr;
                  tail_data <= push_data;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               head_addr <= tail_addr;
               head_data <= tail_data;
               count     <= count - 2'd1;
            end
            // push_ok && pop_ok implies exactly one entry: the new beat becomes the head
            2'b11: begin
               head_addr <= push_addr;
               head_data <= push_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/opsum_collector.sv
// GON output-psum drain: walks (row, col, beat) over the active PE grid, pulls each beat
// with opsum_ready and forwards it with an incrementally generated GLB address.
module opsum_collector
   import pe_array_pkg::*;
#(
   parameter int unsigned PSUM_DATA_SIZE = pe_array_pkg::PSUM_DATA_SIZE,
   parameter int unsigned OPSUM_NUM      = pe_array_pkg::OPSUM_NUM,
   parameter int unsigned ROW_LEN        = pe_array_pkg::ROW_LEN,
   parameter int unsigned ID_LEN         = pe_array_pkg::ID_LEN,
   parameter int unsigned BEAT_LEN       = pe_array_pkg::BEAT_LEN,
   parameter int unsigned ADDR_WIDTH     = pe_array_pkg::ADDR_WIDTH
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [ROW_LEN-1:0]                  cfg_rows,
   input  logic [ID_LEN-1:0]                   cfg_cols,
   input  logic [BEAT_LEN-1:0]                 cfg_beats,
   input  logic [ADDR_WIDTH-1:0]               cfg_base_addr,
   input  logic [ADDR_WIDTH-1:0]               cfg_row_stride,
   output logic                                busy,
   output logic                                done,
   input  logic                                opsum_enable,
   output logic                                opsum_ready,
   output logic [ROW_LEN-1:0]                  opsum_row_tag,
   output logic [ID_LEN-1:0]                   opsum_col_tag,
   input  logic [PSUM_DATA_SIZE*OPSUM_NUM-1:0] opsum_value,
   output logic                                glb_wr_en,
   input  logic                                glb_wr_ready,
   output logic [ADDR_WIDTH-1:0]               glb_wr_addr,
   output logic [PSUM_DATA_SIZE*OPSUM_NUM-1:0] glb_wr_data
);

   localparam int unsigned DATA_WIDTH = PSUM_DATA_SIZE * OPSUM_NUM;

   collector_state_e state, state_next;

   logic [ROW_LEN-1:0]    rows_q, row_q;
   logic [ID_LEN-1:0]     cols_q, col_q;
   logic [BEAT_LEN-1:0]   beats_q, beat_q;
   logic [ADDR_WIDTH-1:0] stride_q, addr_q, row_base_q;

   logic       cfg_empty;
   logic       accept;
   logic       beat_last, col_last, row_last, job_last;
   logic       launch;
   logic       fifo_full, fifo_empty, fifo_pop;
   logic [1:0] fifo_count;

   assign cfg_empty = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_beats == '0);
   assign launch    = (state == ST_IDLE) && start;
   assign accept    = opsum_ready && opsum_enable;
   assign beat_last = (beat_q == beats_q - BEAT_LEN'(1));
   assign col_last  = (col_q == cols_q - ID_LEN'(1));
   assign row_last  = (row_q == rows_q - ROW_LEN'(1));
   assign job_last  = beat_last && col_last && row_last;
   assign glb_wr_en = !fifo_empty;
   assign fifo_pop  = glb_wr_en && glb_wr_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      busy          = 1'b0;
      done          = 1'b0;
      opsum_ready   = 1'b0;
      opsum_row_tag = '0;
      opsum_col_tag = '0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = cfg_empty ? ST_DONE : ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            busy          = 1'b1;
            opsum_ready   = !fifo_full;
            opsum_row_tag = row_q;
            opsum_col_tag = col_q;
            if (accept && job_last) begin
               state_next = ST_DRAIN;
            end
         end
         // leave as soon as the FIFO is known to be empty after this edge
         ST_DRAIN: begin
            busy = 1'b1;
            if (fifo_empty || ((fifo_count == 2'd1) && fifo_pop)) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // row_base_q tracks the first address of the current row so no multiply is needed
   always_ff @(posedge clk) begin
      if (rst) begin
         rows_q     <= '0;
         cols_q     <= '0;
         beats_q    <= '0;
         stride_q   <= '0;
         row_q      <= '0;
         col_q      <= '0;
         beat_q     <= '0;
         addr_q     <= '0;
         row_base_q <= '0;
      end else if (launch) begin
         rows_q     <= cfg_rows;
         cols_q     <= cfg_cols;
         beats_q    <= cfg_beats;
         stride_q   <= cfg_row_stride;
         row_q      <= '0;
         col_q      <= '0;
         beat_q     <= '0;
         addr_q     <= cfg_base_addr;
         row_base_q <= cfg_base_addr;
      end else if (accept) begin
         if (!beat_last) begin
            beat_q <= beat_q + BEAT_LEN'(1);
            addr_q <= addr_q + ADDR_WIDTH'(1);
         end else begin
            beat_q <= '0;
            if (!col_last) begin
               col_q  <= col_q + ID_LEN'(1);
               addr_q <= addr_q + ADDR_WIDTH'(1);
            end else begin
               col_q      <= '0;
               row_q      <= row_q + ROW_LEN'(1);
               row_base_q <= row_base_q + stride_q;
               addr_q     <= row_base_q + stride_q;
            end
         end
      end
   end

   opsum_wr_fifo #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_wr_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_addr (addr_q),
      .push_data (opsum_value),
      .pop       (fifo_pop),
      .head_addr (glb_wr_addr),
      .head_data (glb_wr_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule
